// File: rtl/bram_port_master_pkg.sv
// Shared definitions for the BRAM port initiator: word typedefs, FSM state
// encoding and the full-word byte-enable constant.
package bram_port_master_pkg;

    localparam int REG_WIDTH = 32;

    typedef logic                 bool_t;
    typedef logic [REG_WIDTH-1:0] reg_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RMW_WAIT,
        ST_WRITE,
        ST_RESP
    } bpm_state_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/bram_port_master_byte_merge.sv
// Combinational byte-lane merge: each lane takes new data when its enable is
// set, otherwise keeps the old word's byte.
module bram_port_master_byte_merge
    import bram_port_master_pkg::*;
(
    input  reg_word_t  old_i,
    input  reg_word_t  new_i,
    input  logic [3:0] be_i,
    output reg_word_t  merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bram_port_master.sv
// Initiator for one BRAM port: turns CPU load/store requests into BRAM read
// and write transactions, with read-modify-write for partial stores and a timeout.
module bram_port_master
    import bram_port_master_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_addr,
    input  reg_word_t         req_wdata,
    output logic              resp_valid,
    output reg_word_t         resp_rdata,
    output logic              resp_err,
    output bool_t             bram_read_req,
    output logic [ADDR_W-1:0] bram_addr,
    output bool_t             bram_write_ena,
    output reg_word_t         bram_write_data,
    input  reg_word_t         bram_read_data,
    input  bool_t             bram_read_valid
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bpm_state_t        state_q;
    logic              req_ready_q;
    logic [3:0]        be_q;
    reg_word_t         wdata_q;
    logic [ADDR_W-1:0] bram_addr_q;
    bool_t             read_req_q;
    bool_t             write_ena_q;
    reg_word_t         write_data_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    reg_word_t         resp_rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    reg_word_t         merged;
    logic              accept;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign accept           = req_valid && req_ready_q;
    assign cnt_d            = cnt_q + CNT_W'(1);

    bram_port_master_byte_merge u_merge (
        .old_i    (bram_read_data),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            bram_addr_q  <= '0;
            read_req_q   <= 1'b0;
            write_ena_q  <= 1'b0;
            write_data_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            cnt_q        <= '0;
        end else begin
            read_req_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q  <= 1'b0;
                        bram_addr_q  <= req_addr[ADDR_W+1:2];
                        be_q         <= req_be;
                        wdata_q      <= req_wdata;
                        write_data_q <= req_wdata;
                        cnt_q        <= '0;
                        if (!req_we) begin
                            read_req_q <= 1'b1;
                            state_q    <= ST_RD_WAIT;
                        end else if (req_be == BE_FULL) begin
                            state_q <= ST_WRITE;
                        end else if (req_be == 4'h0) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            state_q      <= ST_RESP;
                        end else begin
                            read_req_q <= 1'b1;
                            state_q    <= ST_RMW_WAIT;
                        end
                    end
                end
                ST_RD_WAIT, ST_RMW_WAIT: begin
                    cnt_q <= cnt_d;
                    if (bram_read_valid) begin
                        if (state_q == ST_RD_WAIT) begin
                            resp_rdata_q <= bram_read_data;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            state_q      <= ST_RESP;
                        end else begin
                            write_data_q <= merged;
                            write_ena_q  <= 1'b1;
                            state_q      <= ST_WRITE;
                        end
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        // Aborted: no write for an RMW, data forced to zero
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    // Full stores arrive here with the strobe low and spend one
                    // setup cycle; merged RMW data arrives with it already set.
                    if (!write_ena_q) begin
                        write_ena_q <= 1'b1;
                    end else begin
                        write_ena_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_err        = resp_err_q;
    assign bram_read_req   = read_req_q;
    assign bram_addr       = bram_addr_q;
    assign bram_write_ena  = write_ena_q;
    assign bram_write_data = write_data_q;

endmodule
